// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: funct3 codes, FSM state encoding and default width for the load/store unit
package dmem_lsu_pkg;
   localparam int XLEN_D = 32;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: pipeline request/response and word-memory bus of the load/store unit
interface dmem_lsu_if #(parameter int XLEN = dmem_lsu_pkg::XLEN_D);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;
   logic            mem_en;
   logic            mem_rw;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_din;
   logic [XLEN-1:0] mem_dout;
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_rw, mem_addr, mem_din
   );
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_rw, mem_addr, mem_din
   );
endinterface

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: load lane extract/extend and sub-word store merge into an old memory word
module dmem_lsu_align import dmem_lsu_pkg::*; #(
   parameter int XLEN = XLEN_D
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      lane,
   input  logic [XLEN-1:0] word,
   input  logic [15:0]     wdata,
   output logic [XLEN-1:0] load,
   output logic [XLEN-1:0] merged
);
   logic [7:0]      b;
   logic [15:0]     h;
   logic [4:0]      sh;
   logic [XLEN-1:0] mask;
   logic [XLEN-1:0] ins;
   always_comb begin
      b = 8'(word >> {lane, 3'b000});
      h = 16'(word >> {lane[1], 4'b0000});
      sh = funct3[0] ? {lane[1], 4'b0000} : {lane, 3'b000};
      mask = funct3[0] ? XLEN'(16'hFFFF) << sh : XLEN'(8'hFF) << sh;
      ins = funct3[0] ? XLEN'(wdata) << sh : XLEN'(wdata[7:0]) << sh;
      merged = (word & ~mask) | ins;
      load = funct3 == F3_B  ? {{(XLEN-8){b[7]}}, b} :
             funct3 == F3_H  ? {{(XLEN-16){h[15]}}, h} :
             funct3 == F3_BU ? XLEN'(b) :
             funct3 == F3_HU ? XLEN'(h) : word;
   end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store initiator for a word memory without byte enables; DMEM_LSU_MISALIGN_TRAP_EN traps misaligned H/W
module dmem_lsu import dmem_lsu_pkg::*; #(
   parameter int MEM_WORDS = 21,
   parameter int XLEN      = XLEN_D
) (
   input logic       clk,
   input logic       rst_n,
   dmem_lsu_if.slave bus
);
   state_t          state, state_n;
   logic            we_q, err_q, bad_f3, oob, mis, err_n, en_n, rw_n;
   logic [2:0]      f3_q;
   logic [15:0]     wdata_q;
   logic [XLEN-1:0] addr_q, cur_addr, din_q, load_w, merge_w;

   assign bad_f3 = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
   assign oob = bus.req_addr[XLEN-1:2] >= (XLEN-2)'(MEM_WORDS);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   assign mis = (bus.req_funct3 inside {F3_H, F3_HU} && bus.req_addr[0]) ||
                (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign err_n = bad_f3 | oob | mis;
   assign cur_addr = state == IDLE ? bus.req_addr : addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         din_q        <= '0;
         bus.mem_en   <= 1'b0;
         bus.mem_rw   <= 1'b0;
         bus.mem_addr <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            err_q   <= err_n;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata[15:0];
         end
         bus.mem_en   <= en_n;
         bus.mem_rw   <= rw_n;
         bus.mem_addr <= en_n ? XLEN'(cur_addr[XLEN-1:2]) : '0;
         din_q        <= state_n == WR ? bus.req_wdata : '0;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.req_valid)
                     state_n = err_n ? RESP : !bus.req_we ? RD : bus.req_funct3 == F3_W ? WR : RMW_RD;
         RD:      state_n = RESP;
         WR:      state_n = RESP;
         RMW_RD:  state_n = RMW_WR;
         RMW_WR:  state_n = RESP;
         default: state_n = IDLE;
      endcase
   end

   // the merge reads the old word straight off mem_dout, valid only during RMW_WR
   always_comb begin
      en_n          = state_n inside {RD, WR, RMW_RD, RMW_WR};
      rw_n          = state_n inside {WR, RMW_WR};
      bus.req_ready = state == IDLE && rst_n;
      bus.rsp_valid = state == RESP;
      bus.rsp_err   = state == RESP && err_q;
      bus.rsp_rdata = state == RESP && !we_q && !err_q ? load_w : '0;
      bus.mem_din   = state == RMW_WR ? merge_w : din_q;
   end

   dmem_lsu_align #(.XLEN(XLEN)) u_align (
      .funct3(f3_q),
      .lane  (addr_q[1:0]),
      .word  (bus.mem_dout),
      .wdata (wdata_q),
      .load  (load_w),
      .merged(merge_w)
   );
endmodule
